// File: rtl/change_dispenser_pkg.sv
// Shared state encoding, coin_sel codes and denomination values
// for the change dispenser.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_RELEASE,
    S_DONE,
    S_FAULT
  } state_t;

  typedef logic [1:0] coin_sel_t;

  localparam coin_sel_t SEL_NONE = 2'b00;
  localparam coin_sel_t SEL_1    = 2'b01;
  localparam coin_sel_t SEL_2    = 2'b10;
  localparam coin_sel_t SEL_5    = 2'b11;

  localparam logic [2:0] VAL_1 = 3'd1;
  localparam logic [2:0] VAL_2 = 3'd2;
  localparam logic [2:0] VAL_5 = 3'd5;

endpackage

// File: rtl/change_dispenser_selector.sv
// Greedy coin choice: largest stocked denomination not exceeding
// the amount still owed.
module coin_selector
  import change_dispenser_pkg::*;
(
  input  logic [3:0] remaining,
  input  logic [2:0] hopper_empty,
  output coin_sel_t  coin_sel,
  output logic [2:0] value,
  output logic       none_avail
);

  always_comb begin
    coin_sel   = SEL_NONE;
    value      = '0;
    none_avail = 1'b0;
    if (remaining >= 4'd5 && !hopper_empty[2]) begin
      coin_sel = SEL_5;
      value    = VAL_5;
    end else if (remaining >= 4'd2 && !hopper_empty[1]) begin
      coin_sel = SEL_2;
      value    = VAL_2;
    end else if (remaining >= 4'd1 && !hopper_empty[0]) begin
      coin_sel = SEL_1;
      value    = VAL_1;
    end else begin
      none_avail = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller: greedy coin ejection with hopper handshake.
// Define CHANGE_DISPENSER_TIMEOUT_EN to fault on a stalled coin_ack.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_amount,
  output logic       req_ready,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  input  logic [2:0] hopper_empty,
  output logic       busy,
  output logic       done,
  output logic       alarm,
  output logic [3:0] dispensed_total
);

  state_t     state;
  logic [3:0] remaining;
  logic [2:0] cur_val;
  coin_sel_t  pick_sel;
  logic [2:0] pick_val;
  logic       none_avail;
  logic       tmo_hit;

  coin_selector u_sel (
    .remaining    (remaining),
    .hopper_empty (hopper_empty),
    .coin_sel     (pick_sel),
    .value        (pick_val),
    .none_avail   (none_avail)
  );

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts the whole eject/release handshake of one coin.
  always_ff @(posedge clk) begin
    if (reset || !(state == S_EJECT || state == S_RELEASE))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      remaining       <= '0;
      dispensed_total <= '0;
      cur_val         <= '0;
      coin_req        <= 1'b0;
      coin_sel        <= SEL_NONE;
      done            <= 1'b0;
      alarm           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            remaining       <= req_amount;
            dispensed_total <= '0;
            alarm           <= 1'b0;
            state           <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining == 4'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (none_avail) begin
            done  <= 1'b1;
            alarm <= 1'b1;
            state <= S_FAULT;
          end else begin
            coin_req <= 1'b1;
            coin_sel <= pick_sel;
            cur_val  <= pick_val;
            state    <= S_EJECT;
          end
        end
        S_EJECT: begin
          if (coin_ack) begin
            remaining       <= remaining - {1'b0, cur_val};
            dispensed_total <= dispensed_total + {1'b0, cur_val};
            coin_req        <= 1'b0;
            coin_sel        <= SEL_NONE;
            state           <= S_RELEASE;
          end else if (tmo_hit) begin
            coin_req <= 1'b0;
            coin_sel <= SEL_NONE;
            done     <= 1'b1;
            alarm    <= 1'b1;
            state    <= S_FAULT;
          end
        end
        S_RELEASE: begin
          // Next coin only once the hopper has released the last one.
          if (!coin_ack) begin
            state <= S_SELECT;
          end else if (tmo_hit) begin
            done  <= 1'b1;
            alarm <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser with a greedy-plan model
// and a hopper responder; checks every cycle after each clock edge.
module tb_change_dispenser;

  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_amount;
  logic       req_ready;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic [2:0] hopper_empty;
  logic       busy;
  logic       done;
  logic       alarm;
  logic [3:0] dispensed_total;

  change_dispenser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_amount      (req_amount),
    .req_ready       (req_ready),
    .coin_req        (coin_req),
    .coin_sel        (coin_sel),
    .coin_ack        (coin_ack),
    .hopper_empty    (hopper_empty),
    .busy            (busy),
    .done            (done),
    .alarm           (alarm),
    .dispensed_total (dispensed_total)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Plan for the pending request, from the greedy rule
  int pend_q[$];
  int pend_fault, pend_total, pend_amt;

  task automatic plan(input int amt, input logic [2:0] he);
    int r;
    r = amt;
    pend_q.delete();
    pend_fault = 0;
    pend_total = 0;
    pend_amt = amt;
    while (r > 0) begin
      if (r >= 5 && !he[2]) begin pend_q.push_back(5); r -= 5; end
      else if (r >= 2 && !he[1]) begin pend_q.push_back(2); r -= 2; end
      else if (r >= 1 && !he[0]) begin pend_q.push_back(1); r -= 1; end
      else begin pend_fault = 1; break; end
    end
    foreach (pend_q[i]) pend_total += pend_q[i];
  endtask

  function automatic int qcode();
    int c;
    c = 0;
    foreach (pend_q[i]) c = c * 10 + pend_q[i];
    return c;
  endfunction

  function automatic int sel_val(input logic [1:0] s);
    case (s)
      2'b01: return 1;
      2'b10: return 2;
      2'b11: return 5;
      default: return 0;
    endcase
  endfunction

  // Hopper responder
  logic [2:0] he_true;
  int ack_dly, ack_hold, hcnt;
  bit ack_never, scramble;

  always @(negedge clk) begin
    if (reset) begin
      coin_ack = 1'b0;
      hcnt = 0;
      hopper_empty = he_true;
    end else if (coin_ack) begin
      if (hcnt >= ack_hold) begin coin_ack = 1'b0; hcnt = 0; end
      else hcnt++;
    end else if (coin_req) begin
      if (!ack_never && hcnt >= ack_dly) begin
        coin_ack = 1'b1;
        hcnt = 0;
        hopper_empty = he_true;
      end else begin
        hcnt++;
        if (scramble) hopper_empty = 3'($urandom);
      end
    end else begin
      hcnt = 0;
      hopper_empty = he_true;
    end
  end

  // Monitor: model state and per-cycle comparisons
  int exp_q[$];
  int exp_fault, exp_total, exp_amt;
  int m_total, m_alarm, cur_val, req_len, busy_cnt, cyc, acc_cyc;
  logic [1:0] cur_sel;
  bit act, prev_ready, prev_req, prev_done;

  initial begin
    act = 0; m_total = 0; m_alarm = 0; cyc = 0;
    prev_ready = 1; prev_req = 0; prev_done = 0;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      chk("rst_coin_req", coin_req, 0);
      chk("rst_coin_sel", coin_sel, 0);
      chk("rst_done", done, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_total", dispensed_total, 0);
      act = 0; m_total = 0; m_alarm = 0;
      exp_q.delete();
    end else begin
      if (prev_ready && req_valid) begin
        act = 1;
        exp_q = pend_q;
        exp_fault = pend_fault;
        exp_total = pend_total;
        exp_amt = pend_amt;
        m_total = 0; m_alarm = 0;
        acc_cyc = cyc - 1;
        busy_cnt = 0;
        chk("acc_total", dispensed_total, 0);
        chk("acc_alarm", alarm, 0);
      end
      chk("ready_vs_busy", req_ready, !busy);
      if (busy) busy_cnt++;
      if (prev_req && coin_ack) begin
        m_total += cur_val;
        chk("req_drop_on_ack", coin_req, 0);
      end
      if (prev_req && !coin_req && !coin_ack) begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        chk("tmo_req_len", req_len, TMO);
`else
        chk("req_drop_no_ack", coin_req, 1);
`endif
      end
      if (coin_req && !prev_req) begin
        chk("coin_pending", int'(exp_q.size() > 0), 1);
        cur_val = 0;
        if (exp_q.size() > 0) cur_val = exp_q.pop_front();
        chk("coin_value", sel_val(coin_sel), cur_val);
        cur_sel = coin_sel;
        req_len = 0;
      end else if (coin_req) begin
        chk("sel_stable", coin_sel, cur_sel);
      end
      if (coin_req) req_len++;
      if (act) chk("total", dispensed_total, m_total);
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        chk("done_busy", busy, 1);
        chk("done_alarm", alarm, exp_fault);
        chk("done_total", dispensed_total, exp_total);
        chk("done_coins_left", exp_q.size(), 0);
        if (exp_amt == 0) begin
          chk("zero_latency", cyc - acc_cyc, 2);
          chk("zero_busy_cycles", busy_cnt, 2);
        end
        m_alarm = exp_fault;
        act = 0;
      end else begin
        chk("alarm_sticky", alarm, m_alarm);
      end
    end
    prev_ready = req_ready;
    prev_req = coin_req;
    prev_done = done;
  end

  // Driver
  task automatic issue(input bit rnd);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1;
    req_amount = pend_amt[3:0];
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin got = 1; break; end
      if (rnd) begin
        req_valid = ($urandom_range(0, 4) == 0);
        req_amount = 4'($urandom);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  task automatic txn(input int amt, input logic [2:0] he, input bit rnd);
    plan(amt, he);
    he_true = he;
    scramble = rnd;
    issue(rnd);
  endtask

  task automatic reset_mid(input int amt);
    bit seen;
    seen = 0;
    plan(amt, 3'b000);
    he_true = 3'b000;
    ack_never = 1;
    req_valid = 1'b1;
    req_amount = amt[3:0];
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (coin_req) seen = 1;
      else @(negedge clk);
    end
    chk("rst_mid_saw_req", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_coin_req", coin_req, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_total", dispensed_total, 0);
    reset = 1'b0;
    ack_never = 0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_amount = '0;
    he_true = 3'b000;
    hopper_empty = 3'b000;
    coin_ack = 1'b0;
    ack_dly = 2; ack_hold = 1;
    ack_never = 0; scramble = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    plan(8, 3'b000);
    chk("model_8_full", qcode(), 521);
    chk("model_8_fault", pend_fault, 0);
    plan(4, 3'b010);
    chk("model_4_no2", qcode(), 1111);
    plan(3, 3'b001);
    chk("model_3_no1", qcode(), 2);
    chk("model_3_fault", pend_fault, 1);
    plan(15, 3'b000);
    chk("model_15", qcode(), 555);

    txn(8, 3'b000, 0);
    txn(4, 3'b010, 0);
    txn(3, 3'b001, 0);
    chk("alarm_after_fault", alarm, 1);
    txn(0, 3'b000, 0);
    chk("alarm_cleared", alarm, 0);
    reset_mid(7);
    txn(15, 3'b000, 0);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    pend_q.delete();
    pend_q.push_back(5);
    pend_fault = 1; pend_total = 0; pend_amt = 5;
    he_true = 3'b000;
    scramble = 0;
    ack_never = 1;
    issue(0);
    ack_never = 0;
    chk("tmo_alarm", alarm, 1);
    chk("tmo_total", dispensed_total, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [2:0] he;
      he = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      ack_dly = $urandom_range(0, 2);
      ack_hold = $urandom_range(0, 2);
      txn($urandom_range(0, 15), he, 1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish, %0d/%0d checks passed", npass, nchk);
    $fatal(1);
  end

endmodule
